// File: rtl/pipe_skid_stage.sv
// Parametrised pipeline stage register carrying an opaque payload.
// MODE=0 is the legacy stall-vector register; MODE=1 is a valid/ready stage with a 2-entry skid buffer.
module pipe_skid_stage #(
  parameter int unsigned       DATA_W     = 128,
  parameter int unsigned       MODE       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall_up,
  input  logic              stall_down,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // M is the register presented downstream; S catches the beat that arrives
  // while M is stalled, so in_ready never depends on out_ready combinationally.
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic              accept;
  logic              drain;

  assign in_ready  = (MODE == 0) ? (!rst && !stall_up) : (!rst && !s_valid_q);
  assign accept    = in_valid && in_ready;
  assign drain     = m_valid_q && out_ready;
  assign out_valid = m_valid_q;
  // Legacy mode exposes the loaded payload even for an invalid beat.
  assign out_data  = (MODE == 0 || m_valid_q) ? m_data_q : BUBBLE_VAL;
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path leaves one unassigned and no latch is inferred.
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;

    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = BUBBLE_VAL;
      s_valid_d = 1'b0;
      s_data_d  = BUBBLE_VAL;
    end else if (MODE == 0) begin
      if (stall_up && !stall_down) begin
        m_valid_d = 1'b0;
        m_data_d  = BUBBLE_VAL;
      end else if (!stall_up) begin
        m_valid_d = in_valid;
        m_data_d  = in_data;
      end
    end else begin
      case ({m_valid_q, s_valid_q})
        2'b00: begin
          if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
          end
        end
        2'b10: begin
          if (accept && drain) begin
            m_data_d = in_data;
          end else if (accept) begin
            s_valid_d = 1'b1;
            s_data_d  = in_data;
          end else if (drain) begin
            m_valid_d = 1'b0;
            m_data_d  = BUBBLE_VAL;
          end
        end
        2'b11: begin
          if (drain) begin
            m_data_d  = s_data_q;
            s_valid_d = 1'b0;
            s_data_d  = BUBBLE_VAL;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= BUBBLE_VAL;
      s_valid_q <= 1'b0;
      s_data_q  <= BUBBLE_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: one legacy-mode and one skid-mode instance, with a
// FIFO scoreboard of accepted beats compared against drained beats.
module tb_pipe_skid_stage;

  localparam int unsigned DW  = 32;
  localparam logic [DW-1:0] BUB = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst, flush;

  logic          m0_stall_up, m0_stall_down, m0_in_valid, m0_in_ready;
  logic          m0_out_valid, m0_out_ready;
  logic [DW-1:0] m0_in_data, m0_out_data;
  logic [1:0]    m0_occupancy;

  logic          m1_in_valid, m1_in_ready, m1_out_valid, m1_out_ready;
  logic [DW-1:0] m1_in_data, m1_out_data;
  logic [1:0]    m1_occupancy;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .MODE(0), .BUBBLE_VAL(BUB)) u_m0 (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_up(m0_stall_up), .stall_down(m0_stall_down),
    .in_valid(m0_in_valid), .in_ready(m0_in_ready), .in_data(m0_in_data),
    .out_valid(m0_out_valid), .out_ready(m0_out_ready), .out_data(m0_out_data),
    .occupancy(m0_occupancy)
  );

  pipe_skid_stage #(.DATA_W(DW), .MODE(1), .BUBBLE_VAL(BUB)) u_m1 (
    .clk(clk), .rst(rst), .flush(flush),
    .stall_up(1'b0), .stall_down(1'b0),
    .in_valid(m1_in_valid), .in_ready(m1_in_ready), .in_data(m1_in_data),
    .out_valid(m1_out_valid), .out_ready(m1_out_ready), .out_data(m1_out_data),
    .occupancy(m1_occupancy)
  );

  // Legacy stage: drive controls, take one edge, land 1 time unit after it.
  task automatic m0_step(input logic su, input logic sd, input logic v, input logic [DW-1:0] d);
    m0_stall_up = su; m0_stall_down = sd; m0_in_valid = v; m0_in_data = d;
    @(posedge clk); #1;
  endtask

  // Skid stage: drive one cycle and report what handshook at the edge.
  task automatic m1_cycle(input logic v, input logic [DW-1:0] d, input logic r,
                          output logic acc, output logic drn, output logic [DW-1:0] od);
    m1_in_valid = v; m1_in_data = d; m1_out_ready = r;
    #1;
    acc = v && m1_in_ready;
    drn = m1_out_valid && r;
    od  = m1_out_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_vec++; if (m0_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_m0_in_ready: got %b want 0", m0_in_ready); end
    n_vec++; if (m1_in_ready !== 1'b0) begin n_err++; $display("FAIL rst_m1_in_ready: got %b want 0", m1_in_ready); end
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (m0_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_m0_out_valid: got %b want 0", m0_out_valid); end
    n_vec++; if (m0_out_data !== BUB) begin n_err++; $display("FAIL rst_m0_out_data: got %h want %h", m0_out_data, BUB); end
    n_vec++; if (m0_occupancy !== 2'd0) begin n_err++; $display("FAIL rst_m0_occ: got %0d want 0", m0_occupancy); end
    n_vec++; if (m1_out_valid !== 1'b0) begin n_err++; $display("FAIL rst_m1_out_valid: got %b want 0", m1_out_valid); end
    n_vec++; if (m1_out_data !== BUB) begin n_err++; $display("FAIL rst_m1_out_data: got %h want %h", m1_out_data, BUB); end
    n_vec++; if (m1_occupancy !== 2'd0) begin n_err++; $display("FAIL rst_m1_occ: got %0d want 0", m1_occupancy); end
    rst = 1'b0;
    #1;
    n_vec++; if (m0_in_ready !== 1'b1) begin n_err++; $display("FAIL rel_m0_in_ready: got %b want 1", m0_in_ready); end
    n_vec++; if (m1_in_ready !== 1'b1) begin n_err++; $display("FAIL rel_m1_in_ready: got %b want 1", m1_in_ready); end
  endtask

  task automatic test_m0_load;
    m0_step(1'b0, 1'b0, 1'b1, 32'h0000_1234);
    n_vec++; if (m0_out_valid !== 1'b1) begin n_err++; $display("FAIL m0_load_valid: got %b want 1", m0_out_valid); end
    n_vec++; if (m0_out_data !== 32'h0000_1234) begin n_err++; $display("FAIL m0_load_data: got %h want 00001234", m0_out_data); end
    n_vec++; if (m0_occupancy !== 2'd1) begin n_err++; $display("FAIL m0_load_occ: got %0d want 1", m0_occupancy); end
    m0_step(1'b0, 1'b0, 1'b0, 32'h0000_0055);
    n_vec++; if (m0_out_valid !== 1'b0) begin n_err++; $display("FAIL m0_inv_valid: got %b want 0", m0_out_valid); end
    n_vec++; if (m0_out_data !== 32'h0000_0055) begin n_err++; $display("FAIL m0_inv_data: got %h want 00000055", m0_out_data); end
    n_vec++; if (m0_occupancy !== 2'd0) begin n_err++; $display("FAIL m0_inv_occ: got %0d want 0", m0_occupancy); end
  endtask

  task automatic test_m0_bubble_hold;
    m0_step(1'b0, 1'b0, 1'b1, 32'h0000_00A5);
    for (int i = 0; i < 3; i++) begin
      m0_stall_up = 1'b1; m0_stall_down = 1'b1; m0_in_valid = 1'b1; m0_in_data = 32'h600 + i;
      #1;
      n_vec++; if (m0_in_ready !== 1'b0) begin n_err++; $display("FAIL m0_hold_in_ready[%0d]: got %b want 0", i, m0_in_ready); end
      @(posedge clk); #1;
      n_vec++; if (m0_out_data !== 32'h0000_00A5) begin n_err++; $display("FAIL m0_hold_data[%0d]: got %h want 000000a5", i, m0_out_data); end
      n_vec++; if (m0_out_valid !== 1'b1) begin n_err++; $display("FAIL m0_hold_valid[%0d]: got %b want 1", i, m0_out_valid); end
    end
    m0_step(1'b1, 1'b0, 1'b1, 32'h0000_0077);
    n_vec++; if (m0_out_valid !== 1'b0) begin n_err++; $display("FAIL m0_bubble_valid: got %b want 0", m0_out_valid); end
    n_vec++; if (m0_out_data !== BUB) begin n_err++; $display("FAIL m0_bubble_data: got %h want %h", m0_out_data, BUB); end
    n_vec++; if (m0_occupancy !== 2'd0) begin n_err++; $display("FAIL m0_bubble_occ: got %0d want 0", m0_occupancy); end
  endtask

  task automatic test_m0_flush;
    m0_step(1'b0, 1'b0, 1'b1, 32'h0000_CAFE);
    flush = 1'b1;
    m0_step(1'b0, 1'b0, 1'b1, 32'h0000_BEEF);
    flush = 1'b0;
    n_vec++; if (m0_out_valid !== 1'b0) begin n_err++; $display("FAIL m0_flush_valid: got %b want 0", m0_out_valid); end
    n_vec++; if (m0_out_data !== BUB) begin n_err++; $display("FAIL m0_flush_data: got %h want %h", m0_out_data, BUB); end
    m0_step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_m1_backpressure;
    logic acc, drn;
    logic [DW-1:0] od, exp;
    logic [DW-1:0] d;
    for (int b = 1; b <= 3; b++) begin
      d = DW'(b);
      m1_cycle(1'b1, d, 1'b0, acc, drn, od);
      n_vec++; if (acc !== (b < 3)) begin n_err++; $display("FAIL bp_accept[%0d]: got %b want %b", b, acc, (b < 3)); end
      if (b > 1) begin
        n_vec++; if (od !== 32'd1) begin n_err++; $display("FAIL bp_stable_data[%0d]: got %h want 00000001", b, od); end
      end
      if (acc) exp_q.push_back(d);
    end
    n_vec++; if (m1_occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_full: got %0d want 2", m1_occupancy); end
    n_vec++; if (m1_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", m1_in_ready); end
    // Upstream keeps offering beat 3 until it is taken.
    for (int c = 0; c < 3; c++) begin
      m1_cycle((c < 2), 32'd3, 1'b1, acc, drn, od);
      n_vec++; if (drn !== 1'b1) begin n_err++; $display("FAIL bp_drain_cycle[%0d]: got %b want 1", c, drn); end
      if (drn) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL bp_extra_beat: got %h, none expected", od);
        end else begin
          exp = exp_q.pop_front();
          n_vec++; if (od !== exp) begin n_err++; $display("FAIL bp_order[%0d]: got %h want %h", c, od, exp); end
        end
      end
      if (acc) exp_q.push_back(32'd3);
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL bp_leftover: got %0d beats pending want 0", exp_q.size()); end
    n_vec++; if (m1_occupancy !== 2'd0) begin n_err++; $display("FAIL bp_occ_empty: got %0d want 0", m1_occupancy); end
  endtask

  task automatic test_back_to_back;
    logic acc, drn;
    logic [DW-1:0] od, exp, d;
    for (int i = 0; i <= 16; i++) begin
      d = 32'h100 + i;
      m1_cycle((i < 16), d, 1'b1, acc, drn, od);
      if (i < 16) begin
        n_vec++; if (acc !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, acc); end
      end
      n_vec++; if (drn !== (i > 0)) begin n_err++; $display("FAIL b2b_out_valid[%0d]: got %b want %b", i, drn, (i > 0)); end
      if (drn) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++; $display("FAIL b2b_extra_beat: got %h, none expected", od);
        end else begin
          exp = exp_q.pop_front();
          n_vec++; if (od !== exp) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, od, exp); end
        end
      end
      if (acc) exp_q.push_back(d);
      n_vec++; if (m1_occupancy > 2'd1) begin n_err++; $display("FAIL b2b_occ[%0d]: got %0d want <=1", i, m1_occupancy); end
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_leftover: got %0d beats pending want 0", exp_q.size()); end
  endtask

  task automatic test_m1_flush;
    logic acc, drn;
    logic [DW-1:0] od, exp;
    m1_cycle(1'b1, 32'd7, 1'b0, acc, drn, od);
    m1_cycle(1'b1, 32'd8, 1'b0, acc, drn, od);
    n_vec++; if (m1_occupancy !== 2'd2) begin n_err++; $display("FAIL fl_occ_full: got %0d want 2", m1_occupancy); end
    flush = 1'b1;
    m1_cycle(1'b1, 32'd9, 1'b1, acc, drn, od);
    flush = 1'b0;
    exp_q.delete();
    n_vec++; if (m1_out_valid !== 1'b0) begin n_err++; $display("FAIL fl_out_valid: got %b want 0", m1_out_valid); end
    n_vec++; if (m1_occupancy !== 2'd0) begin n_err++; $display("FAIL fl_occ: got %0d want 0", m1_occupancy); end
    n_vec++; if (m1_in_ready !== 1'b1) begin n_err++; $display("FAIL fl_in_ready: got %b want 1", m1_in_ready); end
    for (int c = 0; c < 3; c++) begin
      m1_cycle(1'b0, 32'd0, 1'b1, acc, drn, od);
      n_vec++; if (drn !== 1'b0) begin n_err++; $display("FAIL fl_ghost_beat[%0d]: got %h want none", c, od); end
    end
    m1_cycle(1'b1, 32'h10, 1'b1, acc, drn, od);
    if (acc) exp_q.push_back(32'h10);
    m1_cycle(1'b0, 32'd0, 1'b1, acc, drn, od);
    n_vec++; if (drn !== 1'b1) begin n_err++; $display("FAIL fl_resume_valid: got %b want 1", drn); end
    if (drn) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++; $display("FAIL fl_resume_extra: got %h, none expected", od);
      end else begin
        exp = exp_q.pop_front();
        n_vec++; if (od !== exp) begin n_err++; $display("FAIL fl_resume_data: got %h want %h", od, exp); end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic acc, drn;
    logic [DW-1:0] od;
    m1_cycle(1'b1, 32'h21, 1'b0, acc, drn, od);
    m1_cycle(1'b1, 32'h22, 1'b0, acc, drn, od);
    n_vec++; if (m1_occupancy !== 2'd2) begin n_err++; $display("FAIL rm_occ_full: got %0d want 2", m1_occupancy); end
    rst = 1'b1;
    #1;
    n_vec++; if (m1_in_ready !== 1'b0) begin n_err++; $display("FAIL rm_in_ready_rst: got %b want 0", m1_in_ready); end
    repeat (2) @(posedge clk);
    rst = 1'b0;
    m1_in_valid = 1'b0;
    #1;
    exp_q.delete();
    n_vec++; if (m1_out_valid !== 1'b0) begin n_err++; $display("FAIL rm_out_valid: got %b want 0", m1_out_valid); end
    n_vec++; if (m1_out_data !== BUB) begin n_err++; $display("FAIL rm_out_data: got %h want %h", m1_out_data, BUB); end
    n_vec++; if (m1_occupancy !== 2'd0) begin n_err++; $display("FAIL rm_occ: got %0d want 0", m1_occupancy); end
    n_vec++; if (m1_in_ready !== 1'b1) begin n_err++; $display("FAIL rm_in_ready_rel: got %b want 1", m1_in_ready); end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    m0_stall_up = 1'b0; m0_stall_down = 1'b0; m0_in_valid = 1'b0; m0_in_data = '0; m0_out_ready = 1'b1;
    m1_in_valid = 1'b0; m1_in_data = '0; m1_out_ready = 1'b0;
    test_reset;
    test_m0_load;
    test_m0_bubble_hold;
    test_m0_flush;
    test_m1_backpressure;
    test_back_to_back;
    test_m1_flush;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised pipeline stage register; successor to the fixed-field ID/EX register.
- Carries an opaque payload bus of DATA_W bits between any two pipeline stages: IF/ID, ID/EX, EX/MEM or MEM/WB.
- Two modes:
  - MODE=0: legacy stall-vector control (stall_up/stall_down pair plus flush).
  - MODE=1: valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.

Parameters:
- DATA_W, 128: payload width in bits; minimum 1.
- MODE, 1: 0 = legacy stall mode; 1 = valid/ready skid mode.
- BUBBLE_VAL, 0: payload value driven on reset, flush or bubble. Width is DATA_W, zero-extended.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- flush, in, 1: pipeline clear (exception/eret). Synchronous, priority below rst.
- stall_up, in, 1: MODE=0 only; the upstream stage is stalled. Ignored in MODE=1.
- stall_down, in, 1: MODE=0 only; the downstream stage is stalled. Ignored in MODE=1.
- in_valid, in, 1: upstream beat present.
- in_ready, out, 1: stage can accept a beat this cycle.
- in_data, in, DATA_W: upstream payload.
- out_valid, out, 1: downstream beat present.
- out_ready, in, 1: downstream accepts. MODE=0: tie high; ignored.
- out_data, out, DATA_W: downstream payload.
- occupancy, out, 2: entries held, 0..2. MODE=0 range is 0..1.

Behaviour:
- **Reset** (rst=1 at an edge):
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0, skid entry cleared.
  - in_ready=0 while rst is high, combinational in both modes.
- **Flush** (rst=0, flush=1 at an edge): same clearing as reset.
  - Any in_valid beat and any out_ready handshake in that cycle are discarded; no beat is transferred.
  - in_ready=1 on the following cycle.
- **MODE=0**: single register. Priority at each edge:
  1. rst
  2. flush
  3. stall_up=1 and stall_down=0: insert a bubble (out_valid=0, out_data=BUBBLE_VAL).
  4. stall_up=0: load; out_data=in_data, out_valid=in_valid.
  5. Otherwise (stall_up=1, stall_down=1): hold all outputs.
  - in_ready = !rst && !stall_up.
  - Latency is 1 cycle.
- **MODE=1**: main register M plus skid register S.
  - in_ready = !rst && !S.valid, driven from registered state only.
  - Accept beat: in_valid && in_ready. Drain: out_valid && out_ready.
  - out_valid = M.valid; out_data = M.data, or BUBBLE_VAL when M is empty.
  - Transitions per edge, with no flush; the count before the edge selects the row:
    - count 0, accept: M<=in, count 1.
    - count 1, accept and drain: M<=in, count 1.
    - count 1, accept only: S<=in, count 2, in_ready falls next cycle.
    - count 1, drain only: M empties, count 0.
    - count 2, drain: M<=S, S empties, count 1.
    - count 2: no accept is possible.
  - Order is strictly FIFO; no beat is duplicated or lost except at flush.
  - Latency: 1 cycle from accept to out_valid when empty. Full throughput is 1 beat per cycle with out_ready held high.
  - out_data and out_valid hold stable while out_valid=1 and out_ready=0.
  - occupancy = M.valid + S.valid.
- **Payload**: passed bit-exact; no interpretation of fields inside the stage.

Test Plan:
- **T1, MODE=0 load**: rst for 2 cycles, then stall_up=0, in_valid=1, in_data=0x...1234 → next edge out_valid=1, out_data=0x...1234, occupancy=1.
- **T2, MODE=0 bubble and hold**:
  - stall_up=1, stall_down=0 → out_valid=0, out_data=BUBBLE_VAL.
  - Then stall_up=1, stall_down=1 with prior data 0xA5 → out_data stays 0xA5 for 3 cycles.
- **T3, MODE=1 backpressure**:
  - Stream beats 1,2,3 with out_ready=0 → occupancy reaches 2, in_ready=0, beat 3 is not accepted.
  - Then out_ready=1 → outputs 1,2,3 in order on consecutive cycles.
- **T4, MODE=1 throughput**: 16 back-to-back beats with out_ready=1 throughout → 16 outputs on 16 consecutive cycles, occupancy ≤1, in_ready constantly 1.
- **T5, flush with simultaneous handshake**:
  - occupancy=2 holding beats 7,8; flush=1 with in_valid=1 (beat 9) and out_ready=1.
  - Next cycle: out_valid=0, occupancy=0, in_ready=1; beats 7, 8 and 9 never appear.
- **T6, reset mid-stream**: rst asserted while occupancy=2 → in_ready=0 during rst; after release out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
